servo_angle_ramp: RTL and testbench

// - Upstream command stage for the servo PWM generator; drives its angle (pulse-width ticks) and en.
// - Accepts a target in degrees (0-180) over a valid/ready handshake.
// - Converts the target to calibrated pulse-width ticks at 10 MHz.
// - Slews the output toward the target by a bounded step once per 20 ms servo frame, so the servo never jumps.

---
 rtl/servo_pkg.sv | 28 ++
 rtl/servo_frame_timer.sv | 37 +++
 rtl/servo_angle_ramp.sv | 123 ++++++++++++
 tb/tb_servo_angle_ramp.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants, ramp FSM state type and degree-to-pulse conversion for the servo command path.
// FRAME_TICKS is also consumed by the downstream PWM stage so both agree on the frame period.
package servo_pkg;

    localparam int unsigned FRAME_TICKS   = 200000;
    localparam logic [23:0] MIN_PULSE     = 24'd5000;
    localparam logic [23:0] TICKS_PER_DEG = 24'd111;
    localparam logic [23:0] CENTER_PULSE  = 24'd15000;
    localparam logic [23:0] STEP_TICKS    = 24'd200;
    localparam logic [7:0]  DEG_MAX       = 8'd180;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        RAMP,
        HOLD
    } ramp_state_t;

    function automatic logic [7:0] clamp_deg(input logic [7:0] deg);
        return (deg > DEG_MAX) ? DEG_MAX : deg;
    endfunction

    // Caller passes an already-clamped angle, so the result stays within 5000..24980.
    function automatic logic [23:0] deg_to_ticks(input logic [7:0] deg_c);
        return MIN_PULSE + ({16'd0, deg_c} * TICKS_PER_DEG);
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running servo frame counter; frame_tick_o is a registered 1-cycle pulse in the last cycle of each frame.
// No handshake: the counter runs every cycle out of reset.
module servo_frame_timer #(
    parameter int unsigned FRAME_TICKS = servo_pkg::FRAME_TICKS
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic frame_tick_o
);

    localparam int unsigned   CW   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_TICKS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;

    // Tick is derived from the next count so it is high exactly while cnt_q sits at LAST.
    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign frame_tick_o = tick_q;

endmodule

// File: rtl/servo_angle_ramp.sv
// Converts a degree command to calibrated pulse ticks and slews the PWM angle toward it by at most STEP_TICKS per frame.
// Accept -> target registered in 2 cycles; cmd_ready drops only for the single conversion cycle.
module servo_angle_ramp #(
    parameter int unsigned FRAME_TICKS = servo_pkg::FRAME_TICKS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_deg,
    output logic [23:0] angle,
    output logic        en,
    output logic        busy,
    output logic        frame_tick
);

    import servo_pkg::*;

    ramp_state_t        state_q;
    logic [23:0]        angle_q;
    logic [23:0]        angle_d;
    logic [23:0]        target_q;
    logic [7:0]         deg_q;
    logic               armed_q;
    logic               en_q;
    logic               busy_q;
    logic               ready_q;

    logic               tick;
    logic               accept;
    logic signed [24:0] diff;
    logic [24:0]        diff_mag;
    logic               step_fin;
    logic [23:0]        step_angle;

    servo_frame_timer #(
        .FRAME_TICKS (FRAME_TICKS)
    ) u_timer (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .frame_tick_o (tick)
    );

    assign accept = cmd_valid & ready_q;

    // Both operands fit in 24 bits, so a 25-bit signed difference cannot overflow.
    always_comb begin
        diff       = $signed({1'b0, target_q}) - $signed({1'b0, angle_q});
        diff_mag   = diff[24] ? $unsigned(-diff) : $unsigned(diff);
        step_fin   = (diff_mag <= {1'b0, STEP_TICKS});
        step_angle = diff[24] ? (angle_q - STEP_TICKS) : (angle_q + STEP_TICKS);
        angle_d    = step_fin ? target_q : step_angle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            angle_q  <= CENTER_PULSE;
            target_q <= CENTER_PULSE;
            deg_q    <= '0;
            armed_q  <= 1'b0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            if (accept) begin
                deg_q   <= clamp_deg(cmd_deg);
                armed_q <= 1'b1;
            end

            // en follows enable down immediately but only rises on a frame boundary.
            if (!enable) begin
                en_q <= 1'b0;
            end else if (tick && armed_q) begin
                en_q <= 1'b1;
            end

            case (state_q)
                IDLE, HOLD: begin
                    if (accept) begin
                        state_q <= CONV;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                CONV: begin
                    target_q <= deg_to_ticks(deg_q);
                    state_q  <= RAMP;
                    busy_q   <= 1'b1;
                    ready_q  <= 1'b1;
                end
                RAMP: begin
                    // A retarget on the tick cycle still takes this step toward the old target.
                    if (tick && enable) begin
                        angle_q <= angle_d;
                    end
                    if (accept) begin
                        state_q <= CONV;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end else if (tick && enable && step_fin) begin
                        state_q <= HOLD;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign angle      = angle_q;
    assign en         = en_q;
    assign busy       = busy_q;
    assign cmd_ready  = ready_q;
    assign frame_tick = tick;

endmodule

// File: tb/tb_servo_angle_ramp.sv
// Bench for servo_angle_ramp with a shortened frame; a per-cycle reference model plus hand-computed checkpoints.
module tb_servo_angle_ramp;

    localparam int FT   = 100;
    localparam int STEP = 200;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        enable    = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_deg   = 8'd0;
    logic        cmd_ready;
    logic [23:0] angle;
    logic        en;
    logic        busy;
    logic        frame_tick;

    servo_angle_ramp #(.FRAME_TICKS(FT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_deg    (cmd_deg),
        .angle      (angle),
        .en         (en),
        .busy       (busy),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: cycle position in frame, current/target pulse, conversion in flight, ramp active.
    int m_cnt;
    int m_angle;
    int m_target;
    int m_deg;
    bit m_conv;
    bit m_ramp;
    bit m_en;
    bit m_armed;

    typedef struct {
        bit vld;
        int deg;
        int ticks;
        int exp_angle;
        bit exp_en;
        bit exp_busy;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_angle  = 15000;
        m_target = 15000;
        m_deg    = 0;
        m_conv   = 1'b0;
        m_ramp   = 1'b0;
        m_en     = 1'b0;
        m_armed  = 1'b0;
    endtask

    task automatic model_step();
        bit tick;
        bit acc;
        bit fin;
        int d;
        tick = (m_cnt == FT - 1);
        acc  = cmd_valid && !m_conv;
        fin  = 1'b0;
        if (m_ramp && tick && enable) begin
            d = m_target - m_angle;
            if (d <= STEP && d >= -STEP) begin
                m_angle = m_target;
                fin     = 1'b1;
            end else begin
                m_angle = m_angle + ((d > 0) ? STEP : -STEP);
            end
        end
        if (!enable) m_en = 1'b0;
        else if (tick && m_armed) m_en = 1'b1;
        if (acc) begin
            m_deg   = int'(cmd_deg);
            m_armed = 1'b1;
            m_conv  = 1'b1;
            m_ramp  = 1'b0;
        end else if (m_conv) begin
            m_target = 5000 + ((m_deg > 180) ? 180 : m_deg) * 111;
            m_conv   = 1'b0;
            m_ramp   = 1'b1;
        end else if (fin) begin
            m_ramp = 1'b0;
        end
        m_cnt = (m_cnt + 1) % FT;
    endtask

    // One clock: model advances on the edge, outputs compared on the following falling edge.
    task automatic cyc();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
        chk("model_angle", int'(angle), m_angle);
        chk("model_en", int'(en), int'(m_en));
        chk("model_busy", int'(busy), int'(m_conv || m_ramp));
        chk("model_ready", int'(cmd_ready), int'(!m_conv));
        chk("model_frame_tick", int'(frame_tick), int'(m_cnt == FT - 1));
    endtask

    // Run through n frame ticks, then one more cycle so the tick's angle update is visible.
    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            int guard = 0;
            do begin
                cyc();
                guard++;
            end while (!frame_tick && guard < FT + 2);
            chk("tick_seen", int'(frame_tick), 1);
        end
        cyc();
    endtask

    task automatic send(input int deg);
        chk("ready_before_cmd", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_deg   = 8'(deg);
        cyc();
        cmd_valid = 1'b0;
        chk("ready_in_conv", int'(cmd_ready), 0);
        chk("busy_in_conv", int'(busy), 1);
    endtask

    initial begin
        vecs[0] = '{1'b1,  90,  1, 14990, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 180, 49, 24790, 1'b1, 1'b1};
        vecs[2] = '{1'b0,   0,  1, 24980, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 255,  1, 24980, 1'b1, 1'b0};
        vecs[4] = '{1'b1,   0, 10, 22980, 1'b1, 1'b1};
        vecs[5] = '{1'b0,   0, 89,  5180, 1'b1, 1'b1};
        vecs[6] = '{1'b0,   0,  1,  5000, 1'b1, 1'b0};
        vecs[7] = '{1'b1,  90,  3,  5600, 1'b1, 1'b1};

        model_reset();
        enable = 1'b1;
        repeat (3) cyc();
        rst_n = 1'b1;

        chk("rst_angle", int'(angle), 15000);
        chk("rst_en", int'(en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_frame_tick", int'(frame_tick), 0);

        // No command for five frames: output parked at centre, never enabled.
        for (int f = 0; f < 5; f++) begin
            wait_ticks(1);
            chk("idle_angle", int'(angle), 15000);
            chk("idle_en", int'(en), 0);
            chk("idle_busy", int'(busy), 0);
        end

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].vld) send(vecs[i].deg);
            wait_ticks(vecs[i].ticks);
            chk($sformatf("vec%0d_angle", i), int'(angle), vecs[i].exp_angle);
            chk($sformatf("vec%0d_en", i), int'(en), int'(vecs[i].exp_en));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
        end

        // Retarget mid-ramp: climbing at 5600 toward 14990, now head back to 5000.
        send(0);
        wait_ticks(1);
        chk("retarget_reverse", int'(angle), 5400);

        // Accept on the tick cycle: that tick still steps toward 5000, the next toward 24980.
        begin
            int guard = 0;
            while (!frame_tick && guard < FT + 2) begin
                cyc();
                guard++;
            end
            chk("sync_tick_seen", int'(frame_tick), 1);
        end
        cmd_valid = 1'b1;
        cmd_deg   = 8'd180;
        cyc();
        cmd_valid = 1'b0;
        chk("tick_accept_old_target", int'(angle), 5200);
        chk("tick_accept_conv", int'(cmd_ready), 0);
        wait_ticks(1);
        chk("tick_accept_new_target", int'(angle), 5400);

        // Disable mid-ramp: en drops next cycle, angle frozen across ticks.
        enable = 1'b0;
        cyc();
        chk("disable_en", int'(en), 0);
        wait_ticks(2);
        chk("disable_frozen", int'(angle), 5400);
        chk("disable_busy", int'(busy), 1);
        enable = 1'b1;
        cyc();
        chk("reenable_en_waits_tick", int'(en), 0);
        wait_ticks(1);
        chk("reenable_angle", int'(angle), 5600);
        chk("reenable_en", int'(en), 1);

        // Asynchronous reset mid-ramp takes effect without a clock edge.
        repeat (7) cyc();
        rst_n = 1'b0;
        #1;
        chk("arst_angle", int'(angle), 15000);
        chk("arst_en", int'(en), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(cmd_ready), 1);
        model_reset();
        repeat (2) cyc();
        rst_n = 1'b1;
        wait_ticks(1);
        chk("post_rst_en", int'(en), 0);
        chk("post_rst_angle", int'(angle), 15000);

        // Random commands, retargets and enable toggles against the model.
        for (int c = 0; c < 4000; c++) begin
            cmd_valid = ($urandom_range(0, 29) == 0);
            cmd_deg   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 39) == 0) enable = 1'b1;
            cyc();
        end
        cmd_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
